// File: rtl/estufa_climate_ctrl_if.sv
// Sensor inputs, fault-clear request and actuator/status outputs of the
// greenhouse climate controller, bundled for the controller port.
interface estufa_climate_ctrl_if;
  logic       t1;
  logic       t2;
  logic       fault_clr;
  logic       heater;
  logic       cooler;
  logic       fault_led;
  logic [2:0] state;
  logic [7:0] fault_count;

  modport master (
    output t1, t2, fault_clr,
    input  heater, cooler, fault_led, state, fault_count
  );

  modport slave (
    input  t1, t2, fault_clr,
    output heater, cooler, fault_led, state, fault_count
  );
endinterface

// File: rtl/estufa_climate_ctrl.sv
// Greenhouse climate controller: synchronises and debounces the T1/T2
// threshold sensors and drives heater/cooler through a Moore FSM with
// minimum on-time, dead-time and a latched inconsistency fault.
// Optional build macro: ESTUFA_FAULT_COUNT_EN enables the saturating
// FAULT-entry counter; otherwise fault_count is constant zero.
module estufa_climate_ctrl #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned MIN_ON      = 16,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input logic                  clk_2,
  input logic                  reset,
  estufa_climate_ctrl_if.slave bus
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned ON_W   = $clog2(MIN_ON + 1);
  localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [ON_W-1:0]   ON_MAX    = ON_W'(MIN_ON);
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MIN_ON - 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX  = DEAD_W'(DEAD_CYCLES);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAT  = 3'd1,
    COOL  = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Sensor pairs are kept as {t2, t1}
  logic [1:0]        sync1, sync2;
  logic [1:0]        cand;
  logic [1:0]        filt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [ON_W-1:0]   on_cnt;
  logic [DEAD_W-1:0] dead_cnt;
  state_t            state_q, state_next;

  logic is_cold, is_hot, is_bad;

  assign is_cold = (filt == 2'b00);
  assign is_hot  = (filt == 2'b11);
  assign is_bad  = (filt == 2'b10);

  // Two-flop synchroniser followed by the stability filter
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= 2'b01;
      deb_cnt <= '0;
      filt    <= 2'b01;
    end else begin
      sync1 <= {bus.t2, bus.t1};
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else begin
        if (deb_cnt != DEB_MAX)
          deb_cnt <= deb_cnt + DEB_W'(1);
        if (deb_cnt == DEB_LAST)
          filt <= cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Next-state decode; BAD overrides everything except an existing FAULT
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (is_bad)       state_next = FAULT;
        else if (is_cold) state_next = HEAT;
        else if (is_hot)  state_next = COOL;
      end
      HEAT: begin
        if (is_bad)                            state_next = FAULT;
        else if (on_cnt >= ON_LAST && !is_cold) state_next = DEAD;
      end
      COOL: begin
        if (is_bad)                           state_next = FAULT;
        else if (on_cnt >= ON_LAST && !is_hot) state_next = DEAD;
      end
      DEAD: begin
        if (is_bad)                      state_next = FAULT;
        else if (dead_cnt == DEAD_LAST)  state_next = IDLE;
      end
      FAULT: begin
        if (bus.fault_clr && !is_bad) state_next = DEAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Residency counters, cleared whenever the state changes
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      on_cnt   <= '0;
      dead_cnt <= '0;
    end else if (state_next != state_q) begin
      on_cnt   <= '0;
      dead_cnt <= '0;
    end else begin
      if ((state_q == HEAT || state_q == COOL) && on_cnt != ON_MAX)
        on_cnt <= on_cnt + ON_W'(1);
      if (state_q == DEAD && dead_cnt != DEAD_MAX)
        dead_cnt <= dead_cnt + DEAD_W'(1);
    end
  end

  assign bus.heater    = (state_q == HEAT);
  assign bus.cooler    = (state_q == COOL);
  assign bus.fault_led = (state_q == FAULT);
  assign bus.state     = state_q;

`ifdef ESTUFA_FAULT_COUNT_EN
  logic [7:0] fault_cnt;

  // Count entries into FAULT, holding at 255
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset)
      fault_cnt <= '0;
    else if (state_next == FAULT && state_q != FAULT && fault_cnt != '1)
      fault_cnt <= fault_cnt + 8'd1;
  end

  assign bus.fault_count = fault_cnt;
`else
  assign bus.fault_count = '0;
`endif

endmodule
